decode_token: RTL
=================

DECODE_TOKEN -- requirements
Module: decode_token

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 13, giving the width of the bit window received from the input stage.
REQ-002 SHALL have parameter NEED_STR_WIDTH, default 4, giving the width of the consumed-bit count.
REQ-003 SHALL use one clock and an asynchronous, active-high reset. Ports: clk input 1, the rising-edge clock; rst input 1, the async active-high reset.
REQ-004 ce  input  1  enable; the parser leaves S_IDLE only while ce=1.
REQ-005 stream_data  input  IN_WIDTH  left-justified bit window; bit 12 is the next unread compressed bit.
REQ-006 stream_valid  input  1  stream_data is valid.
REQ-007 stream_width  output  NEED_STR_WIDTH  number of bits consumed; meaningful only when stream_ack=1.
REQ-008 stream_ack  output  1  consume stream_width bits this cycle.
REQ-009 current_state  output  3  parser status: WAIT=3'b011, OFULL=3'b110, otherwise the state code.
REQ-010 tok_valid, tok_literal, tok_data[7:0], tok_offset[10:0], tok_length[15:0]  output  registered token slot.
REQ-011 tok_ready  input  1  downstream accepts the token when tok_valid=1.
REQ-012 done  output  1  one-cycle pulse when the end marker is consumed.

Function
REQ-013 SHALL implement these state codes: S_IDLE 000, S_TOKEN 001, S_LEN 010, S_EXT 100, S_END 111.
REQ-014 S_IDLE SHALL go to S_TOKEN when ce=1; in every other state ce is ignored.
REQ-015 stream_ack SHALL be combinational and SHALL be 1 only when the parser is in S_TOKEN, S_LEN or S_EXT, stream_valid=1, and, for steps that emit a token, the slot is free.
REQ-016 The slot is free when tok_valid=0 or tok_ready=1.
REQ-017 S_TOKEN, bit12=0 (literal): width 9; emits tok_literal=1 with tok_data=stream_data[11:4]; stays in S_TOKEN.
REQ-018 S_TOKEN, bits[12:11]=11: width 9, offset=stream_data[10:4]. If the offset is 0 (end marker), the parser goes to S_END with no token emitted. Otherwise the offset is latched and the parser goes to S_LEN.
REQ-019 S_TOKEN, bits[12:11]=10: width 13; latches offset=stream_data[10:0] and goes to S_LEN. This step emits nothing, so no free slot is needed.
REQ-020 S_LEN length codes, taken from bits[12:9]:
- 00xx: length 2, width 2.
- 01xx: length 3, width 2.
- 10xx: length 4, width 2.
- 1100: length 5, width 4.
- 1101: length 6, width 4.
- 1110: length 7, width 4.
- For the codes above, the parser emits the token (tok_literal=0) and returns to S_TOKEN.
- 1111: width 4; latches length 8 and goes to S_EXT with no emission.
REQ-021 S_EXT: width 4, nibble n=bits[12:9], and length is increased by n.
- n=15: no emission; the parser stays in S_EXT.
- n<15: the parser emits the token and returns to S_TOKEN.
- The length SHALL saturate at 16'hFFFF.
REQ-022 An S_EXT step with n=15 SHALL NOT require a free slot; an S_EXT step with n<15 SHALL require one.
REQ-023 The token slot SHALL load on the clock edge where an emitting ack occurs. tok_valid clears on the edge where tok_ready=1 and no new token is loaded. The tok_* outputs SHALL be held unchanged while tok_valid=1 and tok_ready=0.
REQ-024 Emission latency: the token SHALL appear in the tok_* registers on the edge following the consuming ack.
REQ-025 S_END SHALL pulse done for one cycle and then go to S_IDLE. A token pending in the slot SHALL still drain normally.
REQ-026 current_state SHALL read as follows:
- OFULL while in a parse state with stream_valid=1 and an emitting step blocked by the slot.
- Otherwise WAIT while in a parse state with stream_valid=0.
- Otherwise the state code.
REQ-027 When stream_ack=0, stream_width SHALL be 0.

Reset
REQ-028 On rst=1, the state SHALL be S_IDLE, tok_valid, tok_literal and done SHALL be 0, tok_data, tok_offset and tok_length SHALL be 0, and the latched offset and length SHALL be 0.
REQ-029 rst asserted mid-token SHALL discard any partial offset or length and any pending token, with no done pulse.

Verification
REQ-030 ce=1, stream_data=13'h0410 with valid, tok_ready=1 -> ack with width 9; the next cycle gives tok_valid=1, tok_literal=1, tok_data=8'h41.
REQ-031 Short-offset match: window 1_1_0000101 -> ack width 9 and state S_LEN; then window 01x -> ack width 2; then the token has offset 5 and length 3.
REQ-032 Long offset plus extended length: window 10_00000010000 -> width 13 (offset 16); then 1111 -> width 4; then 1111 -> width 4; then 0010 -> width 4; the token has length 25.
REQ-033 Backpressure: tok_valid=1 and tok_ready=0 with a literal window -> stream_ack=0, current_state=3'b110, and the token is held. When tok_ready rises, the ack and the new token follow on the next edge.
REQ-034 End marker 110000000 -> ack width 9, done pulses for one cycle, then state 000. A later window with ce=0 -> no ack.
REQ-035 Assert rst while in S_EXT with a partial length of 23 -> all outputs return to the reset values. Then with ce=1 the next parse starts in S_TOKEN with length 0.

Source files
------------

// File: rtl/decode_token_if.sv
// Bundle of the compressed-stream input and the token-slot output of decode_token.
// The slave modport is the parser side and the master modport is the environment side.
interface decode_token_if #(
    parameter int IN_WIDTH       = 13,
    parameter int NEED_STR_WIDTH = 4
);
    logic                      ce;
    logic [IN_WIDTH-1:0]       stream_data;
    logic                      stream_valid;
    logic [NEED_STR_WIDTH-1:0] stream_width;
    logic                      stream_ack;
    logic [2:0]                current_state;
    logic                      tok_valid;
    logic                      tok_literal;
    logic [7:0]                tok_data;
    logic [10:0]               tok_offset;
    logic [15:0]               tok_length;
    logic                      tok_ready;
    logic                      done;

    modport slave (
        input  ce, stream_data, stream_valid, tok_ready,
        output stream_width, stream_ack, current_state,
               tok_valid, tok_literal, tok_data, tok_offset, tok_length, done
    );

    modport master (
        output ce, stream_data, stream_valid, tok_ready,
        input  stream_width, stream_ack, current_state,
               tok_valid, tok_literal, tok_data, tok_offset, tok_length, done
    );
endinterface

// File: rtl/decode_token.sv
// Bit-window parser that turns an LZ-style compressed stream into literal and match tokens.
// Each acked cycle consumes stream_width bits; emitted tokens land in a one-deep registered slot.
module decode_token #(
    parameter int IN_WIDTH       = 13,
    parameter int NEED_STR_WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    decode_token_if.slave   bus
);
    localparam int MSB = IN_WIDTH - 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_TOKEN = 3'b001,
        S_LEN   = 3'b010,
        S_EXT   = 3'b100,
        S_END   = 3'b111
    } state_t;

    localparam logic [2:0] CS_WAIT  = 3'b011;
    localparam logic [2:0] CS_OFULL = 3'b110;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] n);
        logic [16:0] s;
        s = {1'b0, a} + {13'b0, n};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    state_t      state_q;
    logic [10:0] off_q;
    logic [15:0] len_q;
    logic        tok_valid_q;
    logic        tok_literal_q;
    logic [7:0]  tok_data_q;
    logic [10:0] tok_offset_q;
    logic [15:0] tok_length_q;
    logic        done_q;

    state_t                    nxt_c;
    logic [NEED_STR_WIDTH-1:0] width_c;
    logic                      emit_c;
    logic                      lit_c;
    logic [7:0]                data_c;
    logic                      lat_off_c;
    logic [10:0]               off_c;
    logic                      lat_len_c;
    logic [15:0]               len_c;
    logic                      end_c;
    logic                      parse_c;
    logic                      slot_free_c;
    logic                      ack_c;
    logic [3:0]                code_c;

    // Decode the step the current window would perform if consumed this cycle.
    always_comb begin
        nxt_c     = state_q;
        width_c   = '0;
        emit_c    = 1'b0;
        lit_c     = 1'b0;
        data_c    = 8'h00;
        lat_off_c = 1'b0;
        off_c     = 11'h000;
        lat_len_c = 1'b0;
        len_c     = len_q;
        end_c     = 1'b0;
        code_c    = bus.stream_data[MSB -: 4];
        case (state_q)
            S_TOKEN: begin
                if (!bus.stream_data[MSB]) begin
                    width_c = NEED_STR_WIDTH'(9);
                    emit_c  = 1'b1;
                    lit_c   = 1'b1;
                    data_c  = bus.stream_data[MSB-1 -: 8];
                end else if (bus.stream_data[MSB-1]) begin
                    width_c = NEED_STR_WIDTH'(9);
                    if (bus.stream_data[MSB-2 -: 7] == 7'd0) begin
                        end_c = 1'b1;
                        nxt_c = S_END;
                    end else begin
                        lat_off_c = 1'b1;
                        off_c     = {4'b0, bus.stream_data[MSB-2 -: 7]};
                        nxt_c     = S_LEN;
                    end
                end else begin
                    width_c   = NEED_STR_WIDTH'(13);
                    lat_off_c = 1'b1;
                    off_c     = bus.stream_data[MSB-2 -: 11];
                    nxt_c     = S_LEN;
                end
            end
            S_LEN: begin
                lat_len_c = 1'b1;
                if (code_c[3:2] != 2'b11) begin
                    width_c = NEED_STR_WIDTH'(2);
                    len_c   = 16'd2 + {14'b0, code_c[3:2]};
                    emit_c  = 1'b1;
                    nxt_c   = S_TOKEN;
                end else if (code_c == 4'hF) begin
                    width_c = NEED_STR_WIDTH'(4);
                    len_c   = 16'd8;
                    nxt_c   = S_EXT;
                end else begin
                    width_c = NEED_STR_WIDTH'(4);
                    len_c   = 16'd5 + {14'b0, code_c[1:0]};
                    emit_c  = 1'b1;
                    nxt_c   = S_TOKEN;
                end
            end
            S_EXT: begin
                width_c   = NEED_STR_WIDTH'(4);
                lat_len_c = 1'b1;
                len_c     = sat_add(len_q, code_c);
                if (code_c != 4'hF) begin
                    emit_c = 1'b1;
                    nxt_c  = S_TOKEN;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        parse_c     = (state_q == S_TOKEN) || (state_q == S_LEN) || (state_q == S_EXT);
        slot_free_c = !tok_valid_q || bus.tok_ready;
        ack_c       = parse_c && bus.stream_valid && (!emit_c || slot_free_c);
    end

    // State, latched match fields and the token slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            off_q         <= '0;
            len_q         <= '0;
            tok_valid_q   <= 1'b0;
            tok_literal_q <= 1'b0;
            tok_data_q    <= '0;
            tok_offset_q  <= '0;
            tok_length_q  <= '0;
            done_q        <= 1'b0;
        end else begin
            done_q <= ack_c && end_c;
            case (state_q)
                S_IDLE: if (bus.ce) state_q <= S_TOKEN;
                S_END:  state_q <= S_IDLE;
                default: if (ack_c) state_q <= nxt_c;
            endcase
            if (ack_c && lat_off_c) off_q <= off_c;
            if (ack_c && lat_len_c) len_q <= len_c;
            if (ack_c && emit_c) begin
                tok_valid_q   <= 1'b1;
                tok_literal_q <= lit_c;
                tok_data_q    <= data_c;
                tok_offset_q  <= lit_c ? 11'h000 : off_q;
                tok_length_q  <= lit_c ? 16'h0000 : len_c;
            end else if (bus.tok_ready) begin
                tok_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        if (parse_c && bus.stream_valid && emit_c && !slot_free_c)
            bus.current_state = CS_OFULL;
        else if (parse_c && !bus.stream_valid)
            bus.current_state = CS_WAIT;
        else
            bus.current_state = state_q;
    end

    assign bus.stream_ack   = ack_c;
    assign bus.stream_width = ack_c ? width_c : '0;
    assign bus.tok_valid    = tok_valid_q;
    assign bus.tok_literal  = tok_literal_q;
    assign bus.tok_data     = tok_data_q;
    assign bus.tok_offset   = tok_offset_q;
    assign bus.tok_length   = tok_length_q;
    assign bus.done         = done_q;
endmodule
